adc_sar_controller: RTL and testbench

- Successive-approximation sequencer for the 12-bit capacitive-DAC ADC.
- Produces the 12-bit binary trial code that feeds the row/column thermometer decoder of the capacitor matrix.
- Drives the sample switch and triggers the comparator, then collects one decision per bit, MSB first.
- Delivers the final conversion result with a one-cycle valid pulse.

---
 rtl/adc_sar_controller.sv | 143 ++++++++++++++
 tb/tb_adc_sar_controller.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sar_controller.sv
// adc_sar_controller
// Successive-approximation sequencer for a 12-bit capacitive-DAC ADC.
// One conversion: sample the input for N cycles, then for each bit (MSB
// first) present a trial code, fire the comparator, and keep or drop the
// bit. The final code is published on result_out with a one-cycle done_out.
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   start_in         conversion request, sampled only while idle
//   sample_cycles_in sample phase length in cycles (0 behaves as 1)
//   comp_out_in      comparator decision (1 = Vin >= DAC, keep the bit)
//   comp_done_in     comparator decision valid strobe
//   sample_en_out    sampling switch closed
//   comp_trig_out    one-cycle comparator trigger
//   dac_code_out     trial code to the row/column decoder
//   busy_out         conversion in progress
//   result_out       last completed conversion, held until the next done
//   done_out         one-cycle pulse when result_out updates
//   timeout_err_out  sticky: a decision was forced by timeout
module adc_sar_controller #(
    parameter int WIDTH    = 12,
    parameter int SAMPLE_W = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_in,
    input  logic [SAMPLE_W-1:0] sample_cycles_in,
    input  logic                comp_out_in,
    input  logic                comp_done_in,
    output logic                sample_en_out,
    output logic                comp_trig_out,
    output logic [WIDTH-1:0]    dac_code_out,
    output logic                busy_out,
    output logic [WIDTH-1:0]    result_out,
    output logic                done_out,
    output logic                timeout_err_out
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [BIT_W-1:0] MSB_IDX = BIT_W'(WIDTH - 1);
    // Wait counter runs 0..TIMEOUT-1, so the last value marks the final
    // wait cycle in which a real strobe is still accepted.
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_TRIG,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state;
    logic [SAMPLE_W-1:0] sample_cnt;
    logic [TO_W-1:0]     wait_cnt;
    logic [BIT_W-1:0]    bit_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            sample_cnt      <= '0;
            wait_cnt        <= '0;
            bit_idx         <= MSB_IDX;
            sample_en_out   <= 1'b0;
            comp_trig_out   <= 1'b0;
            dac_code_out    <= '0;
            busy_out        <= 1'b0;
            result_out      <= '0;
            done_out        <= 1'b0;
            timeout_err_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    dac_code_out <= '0;
                    bit_idx      <= MSB_IDX;
                    if (start_in) begin
                        sample_cnt      <= (sample_cycles_in == '0) ? SAMPLE_W'(1)
                                                                    : sample_cycles_in;
                        busy_out        <= 1'b1;
                        timeout_err_out <= 1'b0;
                        sample_en_out   <= 1'b1;
                        state           <= S_SAMPLE;
                    end
                end

                S_SAMPLE: begin
                    if (sample_cnt <= SAMPLE_W'(1)) begin
                        // Sampling ends: open the switch and present the MSB trial.
                        sample_en_out <= 1'b0;
                        dac_code_out  <= {1'b1, {(WIDTH-1){1'b0}}};
                        comp_trig_out <= 1'b1;
                        state         <= S_TRIG;
                    end else begin
                        sample_cnt <= sample_cnt - SAMPLE_W'(1);
                    end
                end

                S_TRIG: begin
                    comp_trig_out <= 1'b0;
                    wait_cnt      <= '0;
                    state         <= S_WAIT;
                end

                S_WAIT: begin
                    // A real strobe in the last wait cycle beats the timeout.
                    if (comp_done_in || (wait_cnt == TO_LAST)) begin
                        dac_code_out[bit_idx] <= comp_done_in & comp_out_in;
                        if (!comp_done_in) begin
                            timeout_err_out <= 1'b1;
                        end
                        if (bit_idx == '0) begin
                            state <= S_DONE;
                        end else begin
                            bit_idx                            <= bit_idx - BIT_W'(1);
                            dac_code_out[bit_idx - BIT_W'(1)] <= 1'b1;
                            comp_trig_out                      <= 1'b1;
                            state                              <= S_TRIG;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end

                S_DONE: begin
                    result_out <= dac_code_out;
                    done_out   <= 1'b1;
                    busy_out   <= 1'b0;
                    bit_idx    <= MSB_IDX;
                    state      <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sar_controller.sv
// tb_adc_sar_controller
// Drives adc_sar_controller with a behavioural comparator (programmable
// per-bit response delay, optional no-response) and checks every conversion
// against an arithmetic SAR reference model.
module tb_adc_sar_controller;

    localparam int WIDTH    = 12;
    localparam int SAMPLE_W = 4;
    localparam int TIMEOUT  = 15;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start_in = 1'b0;
    logic [SAMPLE_W-1:0] sample_cycles_in = '0;
    logic                comp_out_in = 1'b0;
    logic                comp_done_in = 1'b0;
    logic                sample_en_out;
    logic                comp_trig_out;
    logic [WIDTH-1:0]    dac_code_out;
    logic                busy_out;
    logic [WIDTH-1:0]    result_out;
    logic                done_out;
    logic                timeout_err_out;

    adc_sar_controller #(.WIDTH(WIDTH), .SAMPLE_W(SAMPLE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_in         (start_in),
        .sample_cycles_in (sample_cycles_in),
        .comp_out_in      (comp_out_in),
        .comp_done_in     (comp_done_in),
        .sample_en_out    (sample_en_out),
        .comp_trig_out    (comp_trig_out),
        .dac_code_out     (dac_code_out),
        .busy_out         (busy_out),
        .result_out       (result_out),
        .done_out         (done_out),
        .timeout_err_out  (timeout_err_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Comparator behaviour: delay in cycles after the trigger, 0 = never answers.
    int  delay_cfg [WIDTH];
    bit  hold_start  = 1'b0;
    bit  pulse_start = 1'b0;
    bit  spurious    = 1'b0;
    bit  late_strobe = 1'b0;
    int  reset_bit   = -1;

    // Observations from the last conversion.
    logic [WIDTH-1:0] trials[$];
    int               obs_done_idx;
    int               obs_busy;
    int               obs_sample;
    logic             obs_err_start;
    logic             obs_err;
    logic [WIDTH-1:0] obs_result;
    bit               obs_reset;
    logic [2*WIDTH+4:0] obs_rst_vec;

    // Reference model results.
    logic [WIDTH-1:0] exp_trials[$];
    logic [WIDTH-1:0] exp_result;
    int               exp_done_idx;
    logic             exp_err;
    int               exp_sample;

    task automatic set_delays(input int d);
        for (int b = 0; b < WIDTH; b++) delay_cfg[b] = d;
    endtask

    // Plain SAR arithmetic: each bit either waits for the comparator or for
    // the full timeout (which then reads as a 0 decision).
    task automatic model_conv(input logic [WIDTH-1:0] vin, input logic [SAMPLE_W-1:0] ns);
        logic [WIDTH-1:0] code;
        logic [WIDTH-1:0] trial;
        int w;
        int d;
        exp_trials.delete();
        code = '0;
        exp_err = 1'b0;
        exp_sample = (ns == 0) ? 1 : int'(ns);
        exp_done_idx = exp_sample + 1;
        for (int b = WIDTH - 1; b >= 0; b--) begin
            trial = code | (WIDTH'(1) << b);
            exp_trials.push_back(trial);
            d = delay_cfg[b];
            if (d == 0 || d > TIMEOUT) begin
                w = TIMEOUT;
                exp_err = 1'b1;
            end else begin
                w = d;
                if (vin >= trial) code = trial;
            end
            exp_done_idx += 1 + w;
        end
        exp_result = code;
    endtask

    // Runs one conversion, acting as the comparator. Cycle index 0 is the
    // cycle right after the accepting start edge; outputs are read at negedges.
    task automatic run_conversion(input logic [WIDTH-1:0] vin, input logic [SAMPLE_W-1:0] ns);
        int pend;
        int bit_i;
        bit late_armed;
        pend = 0;
        bit_i = WIDTH;
        late_armed = 1'b0;
        trials.delete();
        obs_done_idx = -1;
        obs_busy = 0;
        obs_sample = 0;
        obs_err_start = 1'b1;
        obs_err = 1'b0;
        obs_result = '0;
        obs_reset = 1'b0;
        obs_rst_vec = '1;
        @(negedge clk);
        sample_cycles_in = ns;
        start_in = 1'b1;
        comp_done_in = 1'b0;
        @(posedge clk);
        for (int idx = 0; idx < 400 && obs_done_idx < 0 && !obs_reset; idx++) begin
            @(negedge clk);
            comp_done_in = 1'b0;
            comp_out_in = 1'($urandom_range(0, 1));
            start_in = hold_start | (pulse_start && (idx % 5 == 2));
            if (idx == 0) obs_err_start = timeout_err_out;
            if (busy_out) obs_busy++;
            if (done_out) begin
                obs_done_idx = idx;
                obs_result = result_out;
                obs_err = timeout_err_out;
                start_in = hold_start;
                $display("conv vin=%03h ns=%0d result=%03h done_idx=%0d err=%0b",
                         vin, ns, result_out, idx, timeout_err_out);
            end else if (sample_en_out) begin
                obs_sample++;
                if (spurious) comp_done_in = 1'b1;
            end else if (comp_trig_out) begin
                bit_i--;
                trials.push_back(dac_code_out);
                if (late_armed) begin
                    // Stale strobe for the bit that already timed out.
                    comp_done_in = 1'b1;
                    comp_out_in = 1'b1;
                    late_armed = 1'b0;
                end
                pend = (bit_i >= 0) ? delay_cfg[bit_i] : 0;
                if (pend == 0 && late_strobe) late_armed = 1'b1;
                if (reset_bit >= 0 && reset_bit == bit_i) begin
                    #2 rst_n = 1'b0;
                    #1 obs_rst_vec = {dac_code_out, result_out, done_out, sample_en_out,
                                      comp_trig_out, busy_out, timeout_err_out};
                    obs_reset = 1'b1;
                    @(negedge clk);
                    start_in = 1'b0;
                    comp_done_in = 1'b0;
                    rst_n = 1'b1;
                end
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    comp_done_in = 1'b1;
                    comp_out_in = (vin >= dac_code_out);
                end
            end
        end
        start_in = hold_start;
        comp_done_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dac_code_out !== '0) begin n_errors++; $display("FAIL reset_dac got=%h exp=0", dac_code_out); end
        n_checks++;
        if (result_out !== '0) begin n_errors++; $display("FAIL reset_result got=%h exp=0", result_out); end
        n_checks++;
        if ({done_out, sample_en_out, comp_trig_out, busy_out, timeout_err_out} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {done_out, sample_en_out, comp_trig_out, busy_out, timeout_err_out});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] seq [5];
        seq = '{12'h800, 12'hC00, 12'hA00, 12'hB00, 12'hA80};
        set_delays(1);
        model_conv(12'hA5C, 4'd4);
        run_conversion(12'hA5C, 4'd4);
        n_checks++;
        if (obs_result !== 12'hA5C) begin n_errors++; $display("FAIL basic_result got=%h exp=a5c", obs_result); end
        n_checks++;
        if (obs_done_idx !== 29) begin n_errors++; $display("FAIL basic_done_cycle got=%0d exp=29", obs_done_idx); end
        n_checks++;
        if (obs_busy !== 29) begin n_errors++; $display("FAIL basic_busy got=%0d exp=29", obs_busy); end
        n_checks++;
        if (obs_sample !== 4) begin n_errors++; $display("FAIL basic_sample got=%0d exp=4", obs_sample); end
        n_checks++;
        if (trials.size() !== WIDTH) begin n_errors++; $display("FAIL basic_ntrials got=%0d exp=%0d", trials.size(), WIDTH); end
        for (int i = 0; i < 5 && i < trials.size(); i++) begin
            n_checks++;
            if (trials[i] !== seq[i]) begin n_errors++; $display("FAIL basic_trial%0d got=%h exp=%h", i, trials[i], seq[i]); end
        end
        for (int i = 5; i < WIDTH && i < trials.size(); i++) begin
            n_checks++;
            if (trials[i] !== exp_trials[i]) begin n_errors++; $display("FAIL basic_trial%0d got=%h exp=%h", i, trials[i], exp_trials[i]); end
        end
        n_checks++;
        if (obs_err !== 1'b0) begin n_errors++; $display("FAIL basic_err got=%b exp=0", obs_err); end
        @(negedge clk);
        n_checks++;
        if ({done_out, dac_code_out, result_out} !== {1'b0, 12'h000, 12'hA5C}) begin
            n_errors++;
            $display("FAIL basic_after_done got done=%b dac=%h res=%h exp done=0 dac=000 res=a5c",
                     done_out, dac_code_out, result_out);
        end
    endtask

    task automatic test_extremes();
        logic [WIDTH-1:0] v;
        set_delays(1);
        run_conversion(12'hFFF, 4'd4);
        n_checks++;
        if (obs_result !== 12'hFFF) begin n_errors++; $display("FAIL all_ones got=%h exp=fff", obs_result); end
        run_conversion(12'h000, 4'd4);
        n_checks++;
        if (obs_result !== 12'h000) begin n_errors++; $display("FAIL all_zeros got=%h exp=000", obs_result); end
        v = 12'($urandom);
        model_conv(v, 4'd0);
        run_conversion(v, 4'd0);
        n_checks++;
        if (obs_sample !== 1) begin n_errors++; $display("FAIL ns0_sample got=%0d exp=1", obs_sample); end
        n_checks++;
        if (obs_done_idx !== exp_done_idx) begin n_errors++; $display("FAIL ns0_done got=%0d exp=%0d", obs_done_idx, exp_done_idx); end
        n_checks++;
        if (obs_result !== exp_result) begin n_errors++; $display("FAIL ns0_result got=%h exp=%h", obs_result, exp_result); end
    endtask

    task automatic test_slow_comparator();
        set_delays(5);
        run_conversion(12'hA5C, 4'd4);
        n_checks++;
        if (obs_result !== 12'hA5C) begin n_errors++; $display("FAIL slow_result got=%h exp=a5c", obs_result); end
        n_checks++;
        if (obs_busy !== 4 + WIDTH * 6 + 1) begin n_errors++; $display("FAIL slow_busy got=%0d exp=%0d", obs_busy, 4 + WIDTH * 6 + 1); end
        n_checks++;
        if (obs_err !== 1'b0) begin n_errors++; $display("FAIL slow_err got=%b exp=0", obs_err); end
        set_delays(1);
    endtask

    task automatic test_timeout();
        set_delays(1);
        delay_cfg[7] = 0;
        late_strobe = 1'b1;
        model_conv(12'hABC, 4'd4);
        run_conversion(12'hABC, 4'd4);
        late_strobe = 1'b0;
        n_checks++;
        if (obs_result !== exp_result) begin n_errors++; $display("FAIL timeout_result got=%h exp=%h", obs_result, exp_result); end
        n_checks++;
        if (obs_err !== 1'b1) begin n_errors++; $display("FAIL timeout_err got=%b exp=1", obs_err); end
        n_checks++;
        if (obs_done_idx !== exp_done_idx) begin n_errors++; $display("FAIL timeout_done got=%0d exp=%0d", obs_done_idx, exp_done_idx); end
        @(negedge clk);
        n_checks++;
        if (timeout_err_out !== 1'b1) begin n_errors++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err_out); end
        set_delays(1);
        run_conversion(12'h5A3, 4'd2);
        n_checks++;
        if (obs_err_start !== 1'b0) begin n_errors++; $display("FAIL timeout_clear got=%b exp=0", obs_err_start); end
        n_checks++;
        if (obs_result !== 12'h5A3) begin n_errors++; $display("FAIL timeout_next_result got=%h exp=5a3", obs_result); end
    endtask

    task automatic test_busy_ignore();
        set_delays(1);
        pulse_start = 1'b1;
        spurious = 1'b1;
        run_conversion(12'hA5C, 4'd4);
        pulse_start = 1'b0;
        spurious = 1'b0;
        n_checks++;
        if (obs_result !== 12'hA5C) begin n_errors++; $display("FAIL ignore_result got=%h exp=a5c", obs_result); end
        n_checks++;
        if (obs_done_idx !== 29) begin n_errors++; $display("FAIL ignore_done got=%0d exp=29", obs_done_idx); end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] v;
        logic [SAMPLE_W-1:0] ns;
        bit mismatch;
        for (int it = 0; it < 20; it++) begin
            v = 12'($urandom);
            ns = 4'($urandom_range(0, 15));
            for (int b = 0; b < WIDTH; b++) delay_cfg[b] = $urandom_range(1, TIMEOUT + 3);
            pulse_start = 1'($urandom_range(0, 1));
            spurious = 1'($urandom_range(0, 1));
            model_conv(v, ns);
            run_conversion(v, ns);
            n_checks++;
            if (obs_result !== exp_result) begin n_errors++; $display("FAIL rand%0d_result got=%h exp=%h", it, obs_result, exp_result); end
            n_checks++;
            if (obs_done_idx !== exp_done_idx) begin n_errors++; $display("FAIL rand%0d_done got=%0d exp=%0d", it, obs_done_idx, exp_done_idx); end
            n_checks++;
            if (obs_err !== exp_err) begin n_errors++; $display("FAIL rand%0d_err got=%b exp=%b", it, obs_err, exp_err); end
            n_checks++;
            if (obs_busy !== exp_done_idx) begin n_errors++; $display("FAIL rand%0d_busy got=%0d exp=%0d", it, obs_busy, exp_done_idx); end
            n_checks++;
            if (obs_sample !== exp_sample) begin n_errors++; $display("FAIL rand%0d_sample got=%0d exp=%0d", it, obs_sample, exp_sample); end
            mismatch = (trials.size() != exp_trials.size());
            for (int i = 0; i < trials.size() && i < exp_trials.size(); i++)
                if (trials[i] !== exp_trials[i]) mismatch = 1'b1;
            n_checks++;
            if (mismatch) begin n_errors++; $display("FAIL rand%0d_trials got_n=%0d exp_n=%0d seq differs", it, trials.size(), exp_trials.size()); end
        end
        pulse_start = 1'b0;
        spurious = 1'b0;
        set_delays(1);
    endtask

    task automatic test_back_to_back();
        bit seen;
        set_delays(1);
        hold_start = 1'b1;
        run_conversion(12'h3C7, 4'd3);
        hold_start = 1'b0;
        n_checks++;
        if (obs_result !== 12'h3C7) begin n_errors++; $display("FAIL b2b_result got=%h exp=3c7", obs_result); end
        n_checks++;
        if (busy_out !== 1'b0) begin n_errors++; $display("FAIL b2b_idle_gap got=%b exp=0", busy_out); end
        @(negedge clk);
        n_checks++;
        if ({busy_out, sample_en_out} !== 2'b11) begin n_errors++; $display("FAIL b2b_restart got=%b exp=11", {busy_out, sample_en_out}); end
        start_in = 1'b0;
        comp_done_in = 1'b1;
        comp_out_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done_out) seen = 1'b1;
        end
        comp_done_in = 1'b0;
        n_checks++;
        if (seen !== 1'b1) begin n_errors++; $display("FAIL b2b_second_done got=%b exp=1", seen); end
        n_checks++;
        if (result_out !== 12'hFFF) begin n_errors++; $display("FAIL b2b_second_result got=%h exp=fff", result_out); end
    endtask

    task automatic test_reset_mid();
        set_delays(1);
        reset_bit = 5;
        run_conversion(12'h6B1, 4'd4);
        reset_bit = -1;
        n_checks++;
        if (obs_reset !== 1'b1) begin n_errors++; $display("FAIL rstmid_reached got=%b exp=1", obs_reset); end
        n_checks++;
        if (obs_rst_vec !== '0) begin n_errors++; $display("FAIL rstmid_outputs got=%h exp=0", obs_rst_vec); end
        model_conv(12'h6B1, 4'd4);
        run_conversion(12'h6B1, 4'd4);
        n_checks++;
        if (obs_result !== 12'h6B1) begin n_errors++; $display("FAIL rstmid_after got=%h exp=6b1", obs_result); end
        n_checks++;
        if (obs_done_idx !== exp_done_idx) begin n_errors++; $display("FAIL rstmid_done got=%0d exp=%0d", obs_done_idx, exp_done_idx); end
    endtask

    initial begin
        set_delays(1);
        test_reset();
        test_basic();
        test_extremes();
        test_slow_comparator();
        test_timeout();
        test_busy_ignore();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
